// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bytes needed to cover a chain of the given length.
  function automatic int unsigned nbytes(input int unsigned chain_len);
    return (chain_len + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/ccff_bit_serializer.sv
// Byte load/shift buffer presenting one bit per cycle, MSB first.
// head_bit holds its value once the buffer drains, so a stall never glitches the chain head.
module ccff_bit_serializer
  import ccff_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BYTE_W-1:0] data,
  input  logic              flush,
  output logic              head_bit,
  output logic              shift_en,
  output logic              empty,
  output logic              last
);

  localparam int unsigned CNT_W = $clog2(BYTE_W + 1);

  logic [BYTE_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;

  // The last bit is not shifted away so the head stays stable while waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg     <= '0;
      cnt      <= '0;
      shift_en <= 1'b0;
    end else if (flush) begin
      cnt      <= '0;
      shift_en <= 1'b0;
    end else if (load) begin
      sreg     <= data;
      cnt      <= CNT_W'(BYTE_W);
      shift_en <= 1'b1;
    end else if (cnt > CNT_W'(1)) begin
      sreg <= {sreg[BYTE_W-2:0], 1'b0};
      cnt  <= cnt - CNT_W'(1);
    end else if (cnt == CNT_W'(1)) begin
      cnt      <= '0;
      shift_en <= 1'b0;
    end
  end

  assign head_bit = sreg[BYTE_W-1];
  assign empty    = (cnt == '0);
  assign last     = (cnt == CNT_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Initiator end of the ccff configuration chain: serializes a byte stream into the
// chain head, returns tail bits as readback bytes and optionally verifies them.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned IDX_W     = 16
) (
  input  logic              prog_clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_verify,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [BYTE_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  err_bit_idx
);

  localparam int unsigned      NBYTES   = nbytes(CHAIN_LEN);
  localparam int unsigned      REM_W    = $clog2(NBYTES + 1);
  localparam int unsigned      RB_CNT_W = $clog2(BYTE_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    bit_cnt;
  logic [REM_W-1:0]    byte_rem;
  logic                verify_q;
  logic [BYTE_W-1:0]   rb_acc;
  logic [BYTE_W-1:0]   rb_next;
  logic [RB_CNT_W-1:0] rb_cnt;
  logic                ser_empty;
  logic                ser_last;
  logic                start_ok;
  logic                accept;
  logic                final_shift;

  assign start_ok    = cfg_start & (state_q == IDLE);
  assign accept      = in_valid & in_ready;
  assign final_shift = ccff_shift_en & (bit_cnt == LAST_IDX);
  assign rb_next     = {rb_acc[BYTE_W-2:0], ccff_tail};

  ccff_bit_serializer u_ser (
    .clk      (prog_clk),
    .rst_n    (reset_n),
    .load     (accept),
    .data     (in_data),
    .flush    (final_shift),
    .head_bit (ccff_head),
    .shift_en (ccff_shift_en),
    .empty    (ser_empty),
    .last     (ser_last)
  );

  // State register; busy/done are registered from the next state.
  always_ff @(posedge prog_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == LOAD);
      done    <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) state_d = LOAD;
      end
      LOAD: begin
        in_ready = (ser_empty | ser_last) & (byte_rem != '0);
        if (final_shift) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit/byte counters, tail deserializer and verify compare.
  always_ff @(posedge prog_clk) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      byte_rem    <= '0;
      verify_q    <= 1'b0;
      err         <= 1'b0;
      err_bit_idx <= '0;
      rb_acc      <= '0;
      rb_cnt      <= '0;
      rb_data     <= '0;
      rb_valid    <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (start_ok) begin
        bit_cnt     <= '0;
        byte_rem    <= REM_W'(NBYTES);
        verify_q    <= cfg_verify;
        err         <= 1'b0;
        err_bit_idx <= '0;
        rb_acc      <= '0;
        rb_cnt      <= '0;
      end else begin
        if (accept) byte_rem <= byte_rem - REM_W'(1);
        if (ccff_shift_en) begin
          bit_cnt <= bit_cnt + IDX_W'(1);
          rb_acc  <= rb_next;
          rb_cnt  <= rb_cnt + RB_CNT_W'(1);
          // Partial last byte is left-aligned so its unused LSBs read as zero.
          if ((rb_cnt == RB_CNT_W'(BYTE_W - 1)) || final_shift) begin
            rb_data  <= rb_next << (RB_CNT_W'(BYTE_W - 1) - rb_cnt);
            rb_valid <= 1'b1;
          end
          if (verify_q && !err && (ccff_tail != ccff_head)) begin
            err         <= 1'b1;
            err_bit_idx <= bit_cnt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench: 16- and 12-flop chain models, head/readback scoreboards.
module tb_ccff_chain_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, cfg_start, cfg_verify, in_valid, in_ready;
  logic [7:0]  in_data, rb_data;
  logic        ccff_head, ccff_shift_en, ccff_tail, rb_valid, busy, done, err;
  logic [15:0] err_bit_idx;

  logic        start12, verify12, valid12, ready12;
  logic [7:0]  data12, rbd12;
  logic        head12, sen12, tail12, rbv12, busy12, done12, err12;
  logic [15:0] idx12;

  ccff_chain_loader #(.CHAIN_LEN(16), .IDX_W(16)) dut (
    .prog_clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_verify(cfg_verify),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .rb_data(rb_data),
    .rb_valid(rb_valid), .busy(busy), .done(done), .err(err), .err_bit_idx(err_bit_idx)
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .IDX_W(16)) dut12 (
    .prog_clk(clk), .reset_n(reset_n), .cfg_start(start12), .cfg_verify(verify12),
    .in_data(data12), .in_valid(valid12), .in_ready(ready12), .ccff_head(head12),
    .ccff_shift_en(sen12), .ccff_tail(tail12), .rb_data(rbd12),
    .rb_valid(rbv12), .busy(busy12), .done(done12), .err(err12), .err_bit_idx(idx12)
  );

  int total = 0;
  int bad = 0;

  // External chain models.
  logic [15:0] chain16 = '0;
  logic [11:0] chain12 = '0;
  always @(posedge clk) begin
    if (ccff_shift_en) chain16 <= {chain16[14:0], ccff_head};
    if (sen12)         chain12 <= {chain12[10:0], head12};
  end
  assign ccff_tail = chain16[15];
  assign tail12    = chain12[11];

  bit         hq16[$], hq12[$];
  logic [7:0] rq16[$], rq12[$];
  int n_shift16 = 0, n_shift12 = 0, n_done16 = 0, n_done12 = 0;
  int n_rb16 = 0, n_rb12 = 0, n_stall16 = 0;
  bit seen16 = 1'b0;
  bit eb;
  logic [7:0] er;

  // Scoreboard monitor: pops expected head bits / readback bytes as the DUTs produce them.
  always @(negedge clk) begin
    if (ccff_shift_en) begin
      n_shift16++;
      total++;
      if (hq16.size() == 0) begin
        bad++;
        $display("FAIL head16_extra: shift with head=%b, required no shift", ccff_head);
      end else begin
        eb = hq16.pop_front();
        if (ccff_head !== eb) begin
          bad++;
          $display("FAIL head16: got %b required %b (shift %0d)", ccff_head, eb, n_shift16);
        end
      end
    end
    if (!busy) seen16 = 1'b0;
    else if (ccff_shift_en) seen16 = 1'b1;
    else if (seen16) n_stall16++;
    if (done) n_done16++;
    if (rb_valid) begin
      n_rb16++;
      total++;
      if (rq16.size() == 0) begin
        bad++;
        $display("FAIL rb16_extra: got %h, required no readback", rb_data);
      end else begin
        er = rq16.pop_front();
        if (rb_data !== er) begin
          bad++;
          $display("FAIL rb16: got %h required %h", rb_data, er);
        end
      end
    end
    if (sen12) begin
      n_shift12++;
      total++;
      if (hq12.size() == 0) begin
        bad++;
        $display("FAIL head12_extra: shift with head=%b, required no shift", head12);
      end else begin
        eb = hq12.pop_front();
        if (head12 !== eb) begin
          bad++;
          $display("FAIL head12: got %b required %b", head12, eb);
        end
      end
    end
    if (done12) n_done12++;
    if (rbv12) begin
      n_rb12++;
      total++;
      if (rq12.size() == 0) begin
        bad++;
        $display("FAIL rb12_extra: got %h, required no readback", rbd12);
      end else begin
        er = rq12.pop_front();
        if (rbd12 !== er) begin
          bad++;
          $display("FAIL rb12: got %h required %h", rbd12, er);
        end
      end
    end
  end

  // Runs one pass on the selected DUT; offers n bytes, with `gap` idle ready cycles before byte 2.
  task automatic run_pass(input bit sel, input bit verify, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int n, input int gap,
                          output int acc, output bit to);
    int pb, g, cyc, clen;
    logic [7:0] cur;
    bit rdy, dn, offer;
    clen = sel ? 12 : 16;
    acc = 0; pb = 0; g = 0; cyc = 0; to = 1'b0;
    if (sel) begin start12 = 1'b1; verify12 = verify; end
    else begin cfg_start = 1'b1; cfg_verify = verify; end
    @(negedge clk);
    start12 = 1'b0;
    cfg_start = 1'b0;
    while (1) begin
      rdy = sel ? ready12 : in_ready;
      dn  = sel ? done12 : done;
      if (dn) break;
      cur = (acc == 0) ? b0 : (acc == 1) ? b1 : b2;
      offer = (acc < n);
      if (acc == 1 && g < gap && rdy) begin
        offer = 1'b0;
        g++;
      end
      if (sel) begin valid12 = offer; data12 = cur; end
      else begin in_valid = offer; in_data = cur; end
      if (offer && rdy) begin
        for (int k = 7; k >= 0; k--) begin
          if (pb < clen) begin
            if (sel) hq12.push_back(cur[k]);
            else hq16.push_back(cur[k]);
          end
          pb++;
        end
        acc++;
      end
      @(negedge clk);
      cyc++;
      if (cyc > 200) begin
        to = 1'b1;
        break;
      end
    end
    valid12 = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, ccff_head, ccff_shift_en, rb_valid, busy, done, err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags16: got %b required 0000000",
               {in_ready, ccff_head, ccff_shift_en, rb_valid, busy, done, err});
    end
    total++;
    if ({rb_data, err_bit_idx} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data16: got %h required 000000", {rb_data, err_bit_idx});
    end
    total++;
    if ({ready12, head12, sen12, rbv12, busy12, done12, err12, rbd12, idx12} !== 31'h0) begin
      bad++;
      $display("FAIL reset12: got %h required 0",
               {ready12, head12, sen12, rbv12, busy12, done12, err12, rbd12, idx12});
    end
    reset_n = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, ccff_shift_en, busy} !== 3'b000) begin
      bad++;
      $display("FAIL idle_offer: got ready/shift/busy=%b required 000", {in_ready, ccff_shift_en, busy});
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    int acc, d0, s0, st0;
    bit to;
    d0 = n_done16; s0 = n_shift16; st0 = n_stall16;
    rq16.push_back(8'h00); rq16.push_back(8'h00);
    run_pass(1'b0, 1'b0, 8'hA5, 8'h3C, 8'h00, 2, 0, acc, to);
    total++;
    if (to) begin bad++; $display("FAIL load_timeout: got timeout required done"); end
    total++;
    if (chain16 !== 16'hA53C) begin bad++; $display("FAIL load_chain: got %h required a53c", chain16); end
    total++;
    if (n_done16 - d0 != 1) begin bad++; $display("FAIL load_done: got %0d pulses required 1", n_done16 - d0); end
    total++;
    if (n_shift16 - s0 != 16 || n_stall16 - st0 != 0) begin
      bad++;
      $display("FAIL load_shifts: got %0d shifts %0d stalls required 16 and 0", n_shift16 - s0, n_stall16 - st0);
    end
    total++;
    if ({busy, err} !== 2'b00) begin bad++; $display("FAIL load_end: got busy/err=%b required 00", {busy, err}); end
  endtask

  task automatic test_verify_ok();
    int acc, d0, r0;
    bit to;
    d0 = n_done16; r0 = n_rb16;
    rq16.push_back(8'hA5); rq16.push_back(8'h3C);
    run_pass(1'b0, 1'b1, 8'hA5, 8'h3C, 8'h00, 2, 0, acc, to);
    total++;
    if (to || err !== 1'b0) begin bad++; $display("FAIL verify_ok_err: got err=%b to=%b required 0 0", err, to); end
    total++;
    if (n_rb16 - r0 != 2 || rq16.size() != 0) begin
      bad++;
      $display("FAIL verify_ok_rb: got %0d pulses %0d left required 2 and 0", n_rb16 - r0, rq16.size());
    end
    total++;
    if (n_done16 - d0 != 1) begin bad++; $display("FAIL verify_ok_done: got %0d required 1", n_done16 - d0); end
  endtask

  task automatic test_verify_err();
    int acc, d0;
    bit to;
    d0 = n_done16;
    rq16.push_back(8'hA5); rq16.push_back(8'h3C);
    run_pass(1'b0, 1'b1, 8'hA4, 8'h3C, 8'h00, 2, 0, acc, to);
    total++;
    if (to || err !== 1'b1) begin bad++; $display("FAIL verify_err_flag: got err=%b to=%b required 1 0", err, to); end
    total++;
    if (err_bit_idx !== 16'd7) begin bad++; $display("FAIL verify_err_idx: got %0d required 7", err_bit_idx); end
    total++;
    if (n_done16 - d0 != 1 || chain16 !== 16'hA43C) begin
      bad++;
      $display("FAIL verify_err_done: got %0d pulses chain %h required 1 a43c", n_done16 - d0, chain16);
    end
  endtask

  task automatic test_stall();
    int acc, st0;
    bit to;
    st0 = n_stall16;
    rq16.push_back(8'hA4); rq16.push_back(8'h3C);
    run_pass(1'b0, 1'b0, 8'h0F, 8'hF0, 8'h00, 2, 5, acc, to);
    total++;
    if (to || chain16 !== 16'h0FF0) begin bad++; $display("FAIL stall_chain: got %h to=%b required 0ff0", chain16, to); end
    total++;
    if (n_stall16 - st0 != 5) begin bad++; $display("FAIL stall_len: got %0d required 5", n_stall16 - st0); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL stall_err_clear: got %b required 0", err); end
  endtask

  task automatic test_short_chain();
    int acc, s0;
    bit to;
    s0 = n_shift12;
    rq12.push_back(8'h00); rq12.push_back(8'h00);
    run_pass(1'b1, 1'b0, 8'hFF, 8'hF0, 8'h55, 3, 0, acc, to);
    total++;
    if (to || acc != 2) begin bad++; $display("FAIL short_accept: got %0d bytes to=%b required 2", acc, to); end
    total++;
    if (n_shift12 - s0 != 12 || chain12 !== 12'hFFF) begin
      bad++;
      $display("FAIL short_shift: got %0d shifts chain %h required 12 fff", n_shift12 - s0, chain12);
    end
    rq12.push_back(8'hFF); rq12.push_back(8'hF0);
    run_pass(1'b1, 1'b0, 8'h12, 8'h34, 8'h56, 3, 0, acc, to);
    total++;
    if (to || acc != 2 || chain12 !== 12'h123) begin
      bad++;
      $display("FAIL short_second: got %0d bytes chain %h required 2 123", acc, chain12);
    end
    total++;
    if (rq12.size() != 0 || hq12.size() != 0) begin
      bad++;
      $display("FAIL short_drain: got rb %0d head %0d left required 0 0", rq12.size(), hq12.size());
    end
  endtask

  task automatic test_reset_mid();
    int acc, cnt, d0;
    bit to;
    logic [7:0] b;
    b = 8'hA5;
    cnt = 0;
    cfg_start = 1'b1;
    cfg_verify = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    if (in_ready) for (int k = 7; k >= 0; k--) hq16.push_back(b[k]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (ccff_shift_en) cnt++;
      if (cnt == 5) break;
      @(negedge clk);
    end
    total++;
    if (cnt != 5) begin bad++; $display("FAIL mid_reach: got %0d shifts required 5", cnt); end
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({ccff_shift_en, busy, in_ready} !== 3'b000) begin
      bad++;
      $display("FAIL mid_reset: got shift/busy/ready=%b required 000", {ccff_shift_en, busy, in_ready});
    end
    reset_n = 1'b1;
    hq16.delete();
    rq16.delete();
    @(negedge clk);
    d0 = n_done16;
    rq16.push_back(8'hFE); rq16.push_back(8'h14);
    run_pass(1'b0, 1'b0, 8'hA5, 8'h3C, 8'h00, 2, 0, acc, to);
    total++;
    if (to || chain16 !== 16'hA53C || n_done16 - d0 != 1) begin
      bad++;
      $display("FAIL mid_reload: got chain %h done %0d to=%b required a53c 1 0", chain16, n_done16 - d0, to);
    end
  endtask

  initial begin
    reset_n = 1'b0; cfg_start = 1'b0; cfg_verify = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    start12 = 1'b0; verify12 = 1'b0; valid12 = 1'b0; data12 = 8'h00;
    test_reset();
    test_load();
    test_verify_ok();
    test_verify_err();
    test_stall();
    test_short_chain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
